// File: rtl/fwd_result_buffer.sv
// Two-entry forwarding buffer (MEM and WB results) with load-use stall detection
// and a saturating stall-cycle counter.
module fwd_result_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_regWrite,
    input  logic [4:0]  ex_wa,
    input  logic        ex_is_load,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    input  logic [4:0]  adr1,
    input  logic [4:0]  adr2,
    input  logic [31:0] rf_rs1,
    input  logic [31:0] rf_rs2,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        stall,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  wa;
        logic        is_load;
        logic [31:0] data;
    } entry_t;

    entry_t m_q;
    entry_t w_q;
    logic   load_hit1;
    logic   load_hit2;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; W therefore receives the old M, not the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q.valid   <= ex_regWrite && (ex_wa != 5'd0) && !flush;
            m_q.wa      <= ex_wa;
            m_q.is_load <= ex_is_load;
            m_q.data    <= ex_result;
            w_q.valid   <= m_q.valid;
            w_q.wa      <= m_q.wa;
            w_q.is_load <= m_q.is_load;
            w_q.data    <= m_q.is_load ? mem_rdata : m_q.data;
        end
    end

    // Returns {load_hit_on_m, operand}; M is checked before W so the newest write wins.
    function automatic logic [32:0] lookup(input entry_t m, input entry_t w,
                                           input logic [4:0] adr, input logic [31:0] rf);
        logic        hit;
        logic [31:0] val;
        hit = 1'b0;
        val = rf;
        if (adr == 5'd0) begin
            val = 32'd0;
        end else if (m.valid && (m.wa == adr)) begin
            if (m.is_load) hit = 1'b1;
            else           val = m.data;
        end else if (w.valid && (w.wa == adr)) begin
            val = w.data;
        end
        return {hit, val};
    endfunction

    // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
    always_comb begin
        {load_hit1, rs1_data} = lookup(m_q, w_q, adr1, rf_rs1);
        {load_hit2, rs2_data} = lookup(m_q, w_q, adr2, rf_rs2);
        stall                 = load_hit1 || load_hit2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= 16'd0;
        else if (stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: doc/fwd_result_buffer.md
FWD_RESULT_BUFFER -- requirements
Module: fwd_result_buffer

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; all state updates on posedge clk.
REQ-002 Port: clk  input  1  pipeline clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: ex_regWrite  input  1  EX-stage instruction writes a register.
REQ-005 Port: ex_wa  input  5  EX-stage destination register.
REQ-006 Port: ex_is_load  input  1  EX-stage instruction is a load; result comes from mem_rdata.
REQ-007 Port: ex_result  input  32  EX-stage ALU result.
REQ-008 Port: mem_rdata  input  32  load data for the instruction currently in MEM.
REQ-009 Port: flush  input  1  kill the instruction entering MEM this cycle.
REQ-010 Port: adr1 / adr2  input  5 each  decode-stage source registers.
REQ-011 Port: rf_rs1 / rf_rs2  input  32 each  register-file read data for adr1 / adr2.
REQ-012 Port: rs1_data / rs2_data  output  32 each  forwarded operand values.
REQ-013 Port: stall  output  1  load-use hazard; decode must hold.
REQ-014 Port: stall_count  output  16  saturating count of stall cycles.

Function
REQ-015 SHALL hold two entries: M (instruction in MEM) and W (instruction in WB); each entry has valid, wa[4:0], is_load, data[31:0].
REQ-016 Each posedge: M.valid <= ex_regWrite && (ex_wa != 0) && !flush. M.wa, M.is_load and M.data take ex_wa, ex_is_load and ex_result.
REQ-017 Each posedge: W <= M, except W.data <= mem_rdata when M.is_load, else M.data.
REQ-018 Buffer shifts every cycle regardless of stall; upstream inserts the bubble by driving ex_regWrite=0.
REQ-019 Operand lookup, combinational, per source (adrN, rf_rsN):
  - adrN == 0 -> value 0.
  - M.valid && M.wa==adrN && !M.is_load -> M.data.
  - M.valid && M.wa==adrN && M.is_load -> rf_rsN, and the source contributes to stall.
  - W.valid && W.wa==adrN -> W.data.
  - otherwise -> rf_rsN.
REQ-020 M SHALL take priority over W when both match (newest write wins).
REQ-021 stall = OR of load-hit-on-M over both sources; it is purely combinational from current state and adr1/adr2.
REQ-022 A load in M SHALL be forwarded from W on the following cycle (one stall bubble per load-use pair).
REQ-023 stall_count SHALL increment by 1 each cycle stall==1 and SHALL saturate at 16'hFFFF.
REQ-024 Simultaneous flush and ex_regWrite: flush wins, and M becomes invalid.
REQ-025 x0 is never stored valid and never forwarded.
REQ-026 Latency: a write issued from EX in cycle N is forwardable from M in cycle N+1 and from W in cycle N+2; from cycle N+3 it comes from rf.

Reset
REQ-027 While rst_n==0, M.valid=W.valid=0, all entry fields are 0 and stall_count=0, effective immediately and asynchronously.
REQ-028 During reset, outputs reflect empty entries: rsN_data=rf_rsN (0 for adrN==0) and stall=0.
REQ-029 Reset asserted mid-operation SHALL discard both in-flight entries; there is no pending state after release.

Verification
REQ-030 ALU chain: issue wa=5, ex_result=0x11 at N; at N+1, adr1=5 -> rs1_data=0x11, stall=0.
REQ-031 Load-use: issue load wa=7 at N; at N+1, adr2=7 -> stall=1. Drive mem_rdata=0xCAFE at N+1; at N+2, adr2=7 -> rs2_data=0xCAFE, stall=0, stall_count=1.
REQ-032 Priority: write wa=3=0xA at N and wa=3=0xB at N+1; at N+2, adr1=3 -> 0xB.
REQ-033 x0/flush: ex_wa=0 with ex_regWrite=1 -> never forwarded. Write wa=4 with flush=1 -> at N+1, adr1=4 -> rf_rs1.
REQ-034 Saturation/reset: hold a load hit on M for 70000 cycles -> stall_count=0xFFFF. Pulse rst_n=0 -> stall_count=0, stall=0 immediately.
